// File: rtl/gpr_writeback_file.sv
// ============================================================================
// Module  : gpr_writeback_file
// Purpose : GPR file fed by the MEM/WB stream, with self-clear sequencer,
//           bypassed read ports and a 64-bit retired-instruction counter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module gpr_writeback_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_isValid,
  input  logic [ADDR_WIDTH-1:0] i_regWrAddr,
  input  logic                  i_regWrEnable,
  input  logic [DATA_WIDTH-1:0] i_regWrData,
  input  logic [ADDR_WIDTH-1:0] i_rdAddrA,
  input  logic [ADDR_WIDTH-1:0] i_rdAddrB,
  output logic [DATA_WIDTH-1:0] o_rdDataA,
  output logic [DATA_WIDTH-1:0] o_rdDataB,
  output logic                  o_ready,
  output logic                  o_wrDropped,
  output logic [63:0]           o_retired
);

  localparam logic [ADDR_WIDTH:0]   c_NUM_REGS = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] c_LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ONE      = ADDR_WIDTH'(1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic [ADDR_WIDTH-1:0] r_clearPtr;
  logic [ADDR_WIDTH-1:0] w_clearPtrNext;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  r_wrDropped;
  logic [63:0]           r_retired;

  logic w_wrRequest;
  logic w_wrInRange;
  logic w_commit;

  assign w_wrRequest = i_isValid & i_regWrEnable & (i_regWrAddr != '0);
  assign w_wrInRange = ({1'b0, i_regWrAddr} < c_NUM_REGS);
  assign w_commit    = (r_state == ST_RUN) & w_wrRequest & w_wrInRange;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_INIT;
      r_clearPtr <= c_ONE;
    end else begin
      r_state    <= w_stateNext;
      r_clearPtr <= w_clearPtrNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_clearPtrNext = r_clearPtr;
    if (r_state == ST_INIT) begin
      w_clearPtrNext = r_clearPtr + c_ONE;
      if (r_clearPtr == c_LAST_REG) begin
        w_stateNext = ST_RUN;
      end
    end
  end

  // Storage has no reset of its own; the sequencer walks it back to zero.
  always_ff @(posedge i_clock) begin
    if (r_state == ST_INIT) begin
      r_regs[r_clearPtr] <= '0;
    end else if (w_commit) begin
      r_regs[i_regWrAddr] <= i_regWrData;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wrDropped <= 1'b0;
      r_retired   <= '0;
    end else if (r_state == ST_INIT) begin
      if (w_wrRequest) begin
        r_wrDropped <= 1'b1;
      end
    end else if (i_isValid) begin
      r_retired <= r_retired + 64'd1;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] readPort(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] data;
    data = '0;
    if ((r_state == ST_RUN) && (addr != '0) && ({1'b0, addr} < c_NUM_REGS)) begin
      if (i_isValid && i_regWrEnable && (i_regWrAddr == addr)) begin
        data = i_regWrData;
      end else begin
        data = r_regs[addr];
      end
    end
    return data;
  endfunction

  assign o_rdDataA   = readPort(i_rdAddrA);
  assign o_rdDataB   = readPort(i_rdAddrB);
  assign o_ready     = (r_state == ST_RUN);
  assign o_wrDropped = r_wrDropped;
  assign o_retired   = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_gpr_writeback_file.sv
// Bench for gpr_writeback_file: directed steps plus random writeback traffic
// compared against an array-based reference model.
`default_nettype none

module tb_gpr_writeback_file;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_isValid;
  logic [4:0]  i_regWrAddr;
  logic        i_regWrEnable;
  logic [31:0] i_regWrData;
  logic [4:0]  i_rdAddrA;
  logic [4:0]  i_rdAddrB;
  logic [31:0] o_rdDataA;
  logic [31:0] o_rdDataB;
  logic        o_ready;
  logic        o_wrDropped;
  logic [63:0] o_retired;

  gpr_writeback_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_isValid    (i_isValid),
    .i_regWrAddr  (i_regWrAddr),
    .i_regWrEnable(i_regWrEnable),
    .i_regWrData  (i_regWrData),
    .i_rdAddrA    (i_rdAddrA),
    .i_rdAddrB    (i_rdAddrB),
    .o_rdDataA    (o_rdDataA),
    .o_rdDataB    (o_rdDataB),
    .o_ready      (o_ready),
    .o_wrDropped  (o_wrDropped),
    .o_retired    (o_retired)
  );

  always #5 i_clock = ~i_clock;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural view of the register file.
  logic [31:0] mRegs [32];
  logic        mReady;
  logic        mDropped;
  logic [63:0] mRetired;
  int          mClearEdges;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mRegs[i] = '0;
    mReady      = 1'b0;
    mDropped    = 1'b0;
    mRetired    = '0;
    mClearEdges = 0;
  endtask

  task automatic modelEdge(input logic v, input logic e, input logic [4:0] wa, input logic [31:0] wd);
    if (!mReady) begin
      if (v && e && wa != 0) mDropped = 1'b1;
      mClearEdges++;
      if (mClearEdges == 31) mReady = 1'b1;
    end else begin
      if (v && e && wa != 0) mRegs[wa] = wd;
      if (v) mRetired = mRetired + 64'd1;
    end
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] ra, input logic v, input logic e,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (!mReady || ra == 0) return 32'h0;
    if (v && e && wa == ra) return wd;
    return mRegs[ra];
  endfunction

  // One clock: drive at negedge, check just after, then let the edge happen.
  task automatic cycle(input logic v, input logic e, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
    i_isValid = v; i_regWrEnable = e; i_regWrAddr = wa; i_regWrData = wd;
    i_rdAddrA = ra; i_rdAddrB = rb;
    #1;
    chk("ready",   {63'd0, o_ready},     {63'd0, mReady});
    chk("dropped", {63'd0, o_wrDropped}, {63'd0, mDropped});
    chk("retired", o_retired,            mRetired);
    chk("rdA",     {32'd0, o_rdDataA},   {32'd0, expRead(ra, v, e, wa, wd)});
    chk("rdB",     {32'd0, o_rdDataB},   {32'd0, expRead(rb, v, e, wa, wd)});
    @(posedge i_clock);
    modelEdge(v, e, wa, wd);
    @(negedge i_clock);
  endtask

  // Reset asserted away from any rising edge; outputs must drop immediately.
  task automatic doReset();
    i_reset = 1'b0;
    #1;
    modelReset();
    chk("rst_ready",   {63'd0, o_ready},     64'd0);
    chk("rst_dropped", {63'd0, o_wrDropped}, 64'd0);
    chk("rst_retired", o_retired,            64'd0);
    chk("rst_rdA",     {32'd0, o_rdDataA},   64'd0);
    @(negedge i_clock);
    i_reset = 1'b1;
  endtask

  task automatic idleInit();
    for (int k = 1; k <= 31; k++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd9);
    chk("ready_after_31", {63'd0, o_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        v, e;
    logic [4:0]  wa, ra, rb;
    logic [31:0] wd;
    int          guard;

    i_reset = 1'b0; i_isValid = 1'b0; i_regWrEnable = 1'b0; i_regWrAddr = '0;
    i_regWrData = '0; i_rdAddrA = '0; i_rdAddrB = '0;
    modelReset();
    @(negedge i_clock);
    @(negedge i_clock);
    doReset();

    // INIT phase with a dropped write at edge 10.
    for (int k = 1; k <= 31; k++) begin
      if (k == 10) cycle(1'b1, 1'b1, 5'd4, 32'h55, 5'd5, 5'd4);
      else         cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd4);
      if (k == 30) chk("ready_at_30", {63'd0, o_ready}, 64'd0);
    end
    chk("ready_after_31", {63'd0, o_ready}, 64'd1);
    chk("dropped_sticky", {63'd0, o_wrDropped}, 64'd1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd5);
    chk("x4_after_init", {32'd0, o_rdDataA}, 64'd0);

    doReset();
    idleInit();

    // Write, readback, bypass.
    cycle(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 5'd0, 5'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    cycle(1'b1, 1'b1, 5'd3, 32'h12345678, 5'd3, 5'd3);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    chk("x3_readback", {32'd0, o_rdDataA}, 64'h12345678);

    // x0 write.
    cycle(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    chk("x0_no_drop", {63'd0, o_wrDropped}, 64'd0);

    // Flushed slot and valid non-writing slot.
    cycle(1'b1, 1'b1, 5'd7, 32'h1111, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 5'd7, 32'hAAAA, 5'd7, 5'd7);
    cycle(1'b1, 1'b0, 5'd7, 32'hAAAA, 5'd7, 5'd7);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    chk("x7_kept", {32'd0, o_rdDataA}, 64'h1111);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      v  = 1'($urandom_range(0, 3) != 0);
      e  = 1'($urandom_range(0, 2) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      cycle(v, e, wa, wd, ra, rb);
    end

    // Retired count to 100, then mid-run reset.
    doReset();
    idleInit();
    guard = 0;
    while (mRetired < 64'd99 && guard < 200) begin
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
      guard++;
    end
    cycle(1'b1, 1'b1, 5'd9, 32'h77, 5'd9, 5'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    chk("retired_100", o_retired, 64'd100);
    chk("x9_written", {32'd0, o_rdDataA}, 64'h77);
    doReset();
    idleInit();
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    chk("x9_cleared", {32'd0, o_rdDataA}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gpr_writeback_file.md
Name: gpr_writeback_file

Overview:
- General-purpose register file that receives the writeback stream from the MEM/WB pipeline register. It provides two combinational read ports to decode/execute, with same-cycle writeback bypass.
- After reset it clears itself with an internal sequencer, then holds pipeline issue via a ready flag until the clear completes.
- It also keeps a 64-bit retired-instruction counter, fed by the valid bit of the writeback stream.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports
- ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, number of architectural registers; x0 is hardwired to zero; NUM_REGS <= 2**ADDR_WIDTH, >= 2

Ports:
- i_clock  in  1  clock; all state updates on the rising edge
- i_reset  in  1  reset, asynchronous, active-low
- i_isValid  in  1  writeback slot holds a valid (not flushed) operation
- i_regWrAddr  in  ADDR_WIDTH  destination register
- i_regWrEnable  in  1  operation writes a register
- i_regWrData  in  DATA_WIDTH  writeback value
- i_rdAddrA  in  ADDR_WIDTH  read port A address
- i_rdAddrB  in  ADDR_WIDTH  read port B address
- o_rdDataA  out  DATA_WIDTH  read port A data (combinational)
- o_rdDataB  out  DATA_WIDTH  read port B data (combinational)
- o_ready  out  1  clear sequence done; register file usable
- o_wrDropped  out  1  sticky: a write arrived while not ready
- o_retired  out  64  count of valid operations retired since reset

Behaviour:
- Reset (i_reset=0), asynchronous:
  - state=INIT, clear pointer=1
  - o_ready=0, o_wrDropped=0, o_retired=0
  - register contents are not reset directly; the sequencer clears them
- INIT state:
  - Each rising edge writes 0 to register[clear pointer], then increments the pointer.
  - On the edge that clears NUM_REGS-1, state becomes RUN and o_ready rises.
  - o_ready therefore goes high after exactly NUM_REGS-1 rising edges following reset deassertion (31 edges by default).
- In INIT:
  - o_rdDataA and o_rdDataB are forced to 0.
  - Writes are discarded.
  - Any edge with i_isValid & i_regWrEnable & i_regWrAddr!=0 sets o_wrDropped (sticky until reset).
  - o_retired does not count.
- RUN state, write commit:
  - A write commits on the rising edge when i_isValid=1, i_regWrEnable=1 and i_regWrAddr!=0.
  - i_regWrEnable=1 with i_isValid=0 (flushed slot) writes nothing.
  - Writes to x0 are discarded silently; o_wrDropped is not set.
  - i_regWrAddr >= NUM_REGS: write discarded.
- RUN state, read:
  - Address 0 or address >= NUM_REGS returns 0.
  - Otherwise the port returns the stored value, with bypass: if i_isValid & i_regWrEnable & i_regWrAddr==rdAddr & rdAddr!=0, the port returns i_regWrData in the same cycle.
  - Both ports bypass independently; A==B is legal and both ports return the same value.
- Retired counter:
  - In RUN, o_retired increments by 1 on every edge with i_isValid=1, regardless of i_regWrEnable.
  - Wraps from 2**64-1 to 0 with no flag.
- Reset asserted mid-operation, in either state:
  - Immediate return to INIT with the reset values above.
  - Register contents are cleared again from the beginning.
  - Partially completed writes never commit.
- No internal combinational path from any read address to o_ready.
- Outputs are never X after reset deassertion.

Test Plan:
- Release reset, count edges -> o_ready=0 for edges 1..30, o_ready=1 after edge 31; o_rdDataA on addr 5 reads 0 in both phases.
- RUN: write x3=0xDEADBEEF (valid=1, en=1), next cycle read A=3 -> 0xDEADBEEF; same-cycle read A=3 during a write of x3=0x12345678 -> 0x12345678 (bypass); B=3 matches A.
- Write x0=0xFFFFFFFF -> reads of addr 0 return 0, also during the write cycle; o_wrDropped stays 0.
- Flushed slot: valid=0, en=1, addr 7, data 0xAAAA -> x7 unchanged, no bypass, o_retired unchanged; valid=1, en=0 -> o_retired +1, x7 unchanged.
- During INIT edge 10, issue valid write x4=0x55 -> o_wrDropped=1 and stays 1; after ready, x4 reads 0.
- In RUN at retired count 100, write x9=0x77, then pull i_reset low for one cycle -> o_ready=0, o_retired=0 immediately; after 31 edges x9 reads 0.
